// File: rtl/imem_loader_pkg.sv
// Shared definitions for the IMEM program loader: state encodings,
// frame geometry constants and a small state-classification helper.
package imem_loader_pkg;

    // 3-bit state encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_CHECK  = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;
    localparam logic [2:0] ST_ERROR  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LEN_LO = ST_LEN_LO,
        S_LEN_HI = ST_LEN_HI,
        S_DATA   = ST_DATA,
        S_WRITE  = ST_WRITE,
        S_CHECK  = ST_CHECK,
        S_DONE   = ST_DONE,
        S_ERROR  = ST_ERROR
    } state_t;

    // Frame header is a 16-bit little-endian word count
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // States in which the loader is consuming stream bytes (and the
    // inter-byte timeout is running)
    function automatic logic is_rx_state(input state_t s);
        return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/imem_program_loader_word_assembler.sv
// Byte-lane assembler: shifts payload bytes into a little-endian word,
// keeps the running XOR checksum and flags the byte that completes a word.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_clear,
    input  logic                          i_shift,
    input  logic [7:0]                    i_byte,
    output logic [8*BYTES_PER_WORD-1:0]   o_word_next,
    output logic                          o_word_full,
    output logic [7:0]                    o_checksum
);

    localparam int LANE_W = $clog2(BYTES_PER_WORD);

    logic [LANE_W-1:0]             r_lane;
    logic [8*BYTES_PER_WORD-1:0]   r_word;
    logic [7:0]                    r_cks;

    // The word as it will look once the current byte lands in its lane;
    // the top latches this directly so the write leaves one cycle after
    // the last byte instead of two.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign o_word_next[8*gi +: 8] = (r_lane == LANE_W'(gi)) ? i_byte : r_word[8*gi +: 8];
        end
    endgenerate

    assign o_word_full = i_shift && (r_lane == LANE_W'(BYTES_PER_WORD - 1));
    assign o_checksum  = r_cks;

    // Lane counter, word register and checksum; cleared at frame start
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_lane <= '0;
            r_word <= '0;
            r_cks  <= '0;
        end else if (i_shift) begin
            r_word <= o_word_next;
            r_lane <= r_lane + 1'b1;
            r_cks  <= r_cks ^ i_byte;
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// Boot loader: receives a framed program over a byte stream, writes the
// assembled words to IMEM at 0,4,8,... and releases the core reset only
// after the frame checksum matches.
module imem_program_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_BYTES  = 256,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam int MAX_WORDS = IMEM_BYTES / BYTES_PER_WORD;
    localparam int IDX_W     = ADDR_W - 2;
    localparam int TMO_W     = $clog2(TIMEOUT_CYC + 1);

    state_t              r_state;
    logic                r_byte_ready;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [31:0]         r_imem_wdata;
    logic                r_cpu_reset;
    logic                r_done;
    logic                r_error;
    logic [15:0]         r_len;
    logic [IDX_W-1:0]    r_idx;
    logic [TMO_W-1:0]    r_tmo;

    logic                w_xfer;
    logic                w_clear;
    logic                w_shift;
    logic [15:0]         w_len_rx;
    logic                w_last_word;
    logic                w_rx_state;
    logic                w_tmo_hit;
    logic [31:0]         w_word_next;
    logic                w_word_full;
    logic [7:0]          w_checksum;

    assign w_xfer      = byte_valid && r_byte_ready;
    assign w_clear     = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
    assign w_shift     = w_xfer && (r_state == S_DATA);
    assign w_len_rx    = {byte_data, r_len[7:0]};
    assign w_last_word = ((16'(r_idx) + 16'd1) == r_len);
    assign w_rx_state  = is_rx_state(r_state);
    assign w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

    word_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_shift     (w_shift),
        .i_byte      (byte_data),
        .o_word_next (w_word_next),
        .o_word_full (w_word_full),
        .o_checksum  (w_checksum)
    );

    // Frame FSM with registered outputs, word index and inter-byte timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_byte_ready <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_reset  <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_len        <= '0;
            r_idx        <= '0;
            r_tmo        <= '0;
        end else begin
            r_imem_we <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state      <= S_LEN_LO;
                        r_byte_ready <= 1'b1;
                        r_cpu_reset  <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_idx        <= '0;
                        r_tmo        <= '0;
                    end
                end

                S_LEN_LO: begin
                    if (w_xfer) begin
                        r_len[7:0] <= byte_data;
                        r_state    <= S_LEN_HI;
                    end
                end

                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_len[15:8] <= byte_data;
                        if (w_len_rx == 16'd0) begin
                            r_state <= S_CHECK;
                        end else if (w_len_rx > 16'(MAX_WORDS)) begin
                            // Oversized program: reject before touching IMEM
                            r_state      <= S_ERROR;
                            r_byte_ready <= 1'b0;
                            r_error      <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (w_xfer && w_word_full) begin
                        r_state      <= S_WRITE;
                        r_byte_ready <= 1'b0;
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= {r_idx, 2'b00};
                        r_imem_wdata <= w_word_next;
                    end
                end

                S_WRITE: begin
                    r_idx        <= r_idx + 1'b1;
                    r_byte_ready <= 1'b1;
                    r_state      <= w_last_word ? S_CHECK : S_DATA;
                end

                S_CHECK: begin
                    if (w_xfer) begin
                        r_byte_ready <= 1'b0;
                        if (byte_data == w_checksum) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_byte_ready <= 1'b0;
                end
            endcase

            // Idle-cycle watchdog while receiving; the case above leaves
            // state alone on non-transfer cycles, so this never collides.
            if (w_rx_state) begin
                if (w_xfer) begin
                    r_tmo <= '0;
                end else if (w_tmo_hit) begin
                    r_state      <= S_ERROR;
                    r_byte_ready <= 1'b0;
                    r_error      <= 1'b1;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end
        end
    end

    assign byte_ready = r_byte_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_reset  = r_cpu_reset;
    assign done       = r_done;
    assign error      = r_error;

endmodule
